// File: rtl/acc_core_pkg.sv
// acc_core_pkg: opcode and state types plus operand-width helper shared by acc_core.
// SHL/SHR are only implemented when ACC_CORE_SHIFT_EN is defined.
package acc_core_pkg;
    typedef enum logic [3:0] {
        OP_NOT, OP_XOR, OP_AND, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_OR,
        OP_JMP, OP_JZ, OP_JC, OP_SHL, OP_SHR, OP_LDI, OP_NOP, OP_HALT
    } opcode_e;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPERAND, S_EXECUTE, S_HALT} state_e;

    function automatic int operand_width(int dw);
        return dw - 4;
    endfunction
endpackage

// File: rtl/acc_core_alu.sv
// acc_core_alu: combinational accumulator datapath; writes_acc is low for opcodes that leave acc alone.
// SHL/SHR only decode when ACC_CORE_SHIFT_EN is defined, otherwise they behave as NOP.
module acc_core_alu
    import acc_core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] m,
    input  logic          carry_in,
    output logic [DW-1:0] result,
    output logic          carry_out,
    output logic          writes_acc
);
    logic [DW:0] sum, diff;

    assign sum  = {1'b0, acc} + {1'b0, m};
    assign diff = {1'b0, acc} - {1'b0, m};

    // diff[DW] is the borrow: set exactly when m > acc
    always_comb begin
        result     = acc;
        carry_out  = carry_in;
        writes_acc = 1'b1;
        case (opcode_e'(op))
            OP_NOT:  result = ~m;
            OP_XOR:  result = acc ^ m;
            OP_AND:  result = acc & m;
            OP_OR:   result = acc | m;
            OP_LOAD: result = m;
            OP_LDI:  result = m;
            OP_ADD:  {carry_out, result} = sum;
            OP_SUB:  {carry_out, result} = diff;
`ifdef ACC_CORE_SHIFT_EN
            OP_SHL:  {carry_out, result} = {acc, 1'b0};
            OP_SHR:  {result, carry_out} = {1'b0, acc};
`endif
            default: writes_acc = 1'b0;
        endcase
    end
endmodule

// File: rtl/acc_core.sv
// acc_core: multi-cycle accumulator CPU with one request/ready memory port.
// Define ACC_CORE_SHIFT_EN to enable the SHL/SHR opcodes.
module acc_core
    import acc_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter logic [AW-1:0] DATA_BASE = 'hF0
) (
    input  logic          clock,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] acc,
    output logic          zero,
    output logic          carry,
    output logic          halted
);
    localparam int OW = operand_width(DW);

    state_e        state_q, state_d;
    opcode_e       op;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d, acc_q, acc_d, m_q, m_d, alu_m, alu_result;
    logic          zero_q, zero_d, carry_q, carry_d, alu_carry, alu_we;
    logic [OW-1:0] operand;
    logic          is_store, take_jump;

    assign op        = opcode_e'(ir_q[DW-1:DW-4]);
    assign operand   = ir_q[OW-1:0];
    assign is_store  = op == OP_STORE;
    assign alu_m     = op == OP_LDI ? DW'(operand) : m_q;
    assign take_jump = op == OP_JMP || (op == OP_JZ && zero_q) || (op == OP_JC && carry_q);

    acc_core_alu #(.DW(DW)) u_alu (
        .op(op),
        .acc(acc_q),
        .m(alu_m),
        .carry_in(carry_q),
        .result(alu_result),
        .carry_out(alu_carry),
        .writes_acc(alu_we)
    );

    // Gating with reset drops an in-flight request in the same cycle reset asserts
    assign mem_req   = (state_q == S_FETCH || state_q == S_OPERAND) && !reset;
    assign mem_we    = state_q == S_OPERAND && is_store;
    assign mem_addr  = state_q == S_OPERAND ? DATA_BASE + AW'(operand) : pc_q;
    assign mem_wdata = mem_we ? acc_q : '0;

    assign pc     = pc_q;
    assign ir     = ir_q;
    assign acc    = acc_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign halted = state_q == S_HALT;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        m_d     = m_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + AW'(1);
                state_d = S_DECODE;
            end
            S_DECODE: state_d = ir_q[DW-1] ? S_EXECUTE : S_OPERAND;
            S_OPERAND: if (mem_ready) begin
                m_d     = is_store ? m_q : mem_rdata;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (alu_we) begin
                    acc_d  = alu_result;
                    zero_d = alu_result == '0;
                end
                carry_d = alu_carry;
                pc_d    = take_jump ? AW'(operand) : pc_q;
                state_d = op == OP_HALT ? S_HALT : S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end
endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: directed programs against an instruction-level model of acc_core,
// checked at every memory handshake plus hand-computed architectural expectations.
module tb_acc_core;
`ifdef ACC_CORE_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mem_req, mem_we, mem_ready, zero, carry, halted;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, pc, ir, acc;

    logic [7:0] ram   [256];
    logic [7:0] image [256];
    logic       load  = 1'b0;
    int         stall = 0;
    int         waited = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [7:0] m_pc, m_acc, m_ir, p_addr, p_wdata;
    logic       m_z, m_c, m_halt, m_pend, p_stall, p_we;

    acc_core dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc(pc), .ir(ir), .acc(acc), .zero(zero), .carry(carry), .halted(halted)
    );

    always #5 clock = ~clock;

    // Memory responder: each request waits 'stall' cycles before ready
    assign mem_ready = mem_req && waited >= stall;
    assign mem_rdata = mem_ready ? ram[mem_addr] : 8'hA5;

    always @(posedge clock) begin
        waited <= (mem_req && !mem_ready) ? waited + 1 : 0;
        if (load)
            for (int i = 0; i < 256; i++) ram[i] <= image[i];
        else if (mem_req && mem_we && mem_ready)
            ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr_acc(input logic [7:0] v);
        m_acc = v;
        m_z   = v == 8'h00;
    endtask

    // ISA-level semantics of one instruction with memory operand m
    task automatic exec(input logic [7:0] ins, input logic [7:0] m);
        logic [8:0] w;
        logic [7:0] t;
        t = {4'h0, ins[3:0]};
        case (ins[7:4])
            4'h0: wr_acc(~m);
            4'h1: wr_acc(m_acc ^ m);
            4'h2: wr_acc(m_acc & m);
            4'h4: wr_acc(m);
            4'h5: begin w = m_acc + m; m_c = w[8]; wr_acc(w[7:0]); end
            4'h6: begin m_c = m > m_acc; wr_acc(m_acc - m); end
            4'h7: wr_acc(m_acc | m);
            4'h8: m_pc = t;
            4'h9: if (m_z) m_pc = t;
            4'hA: if (m_c) m_pc = t;
            4'hB: if (SHIFT_EN) begin m_c = m_acc[7]; wr_acc(m_acc << 1); end
            4'hC: if (SHIFT_EN) begin m_c = m_acc[0]; wr_acc(m_acc >> 1); end
            4'hD: wr_acc(t);
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    always @(negedge clock) begin
        if (reset) begin
            m_pc = 8'h00; m_acc = 8'h00; m_ir = 8'h00;
            m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0; m_pend = 1'b0; p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_req", mem_req, 1);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_we", mem_we, p_we);
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            p_stall = mem_req && !mem_ready;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
            if (m_halt) chk("halt_req", mem_req, 0);
            else if (mem_req && mem_ready) begin
                if (!m_pend) begin
                    chk("fetch_addr", mem_addr, m_pc);
                    chk("fetch_we", mem_we, 0);
                    chk("arch_pc", pc, m_pc);
                    chk("arch_acc", acc, m_acc);
                    chk("arch_zero", zero, m_z);
                    chk("arch_carry", carry, m_c);
                    m_ir = ram[m_pc];
                    m_pc = m_pc + 8'h01;
                    if (m_ir[7]) exec(m_ir, 8'h00);
                    else m_pend = 1'b1;
                end else begin
                    chk("opnd_addr", mem_addr, 8'hF0 + {4'h0, m_ir[3:0]});
                    chk("opnd_we", mem_we, m_ir[7:4] == 4'h3);
                    if (m_ir[7:4] == 4'h3) chk("store_data", mem_wdata, m_acc);
                    m_pend = 1'b0;
                    exec(m_ir, ram[mem_addr]);
                end
            end
        end
    end

    task automatic start(input int st);
        reset = 1'b1;
        stall = st;
        for (int i = 0; i < 256; i++) image[i] = 8'hE0;
    endtask

    task automatic go();
        load = 1'b1;
        @(posedge clock); #1 load = 1'b0;
        @(negedge clock);
        @(posedge clock); #2 reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // LDI 5; ADD [F1]; STORE [F2]; HALT
        start(0);
        image[8'h00] = 8'hD5; image[8'h01] = 8'h51; image[8'h02] = 8'h32; image[8'h03] = 8'hF0;
        image[8'hF1] = 8'h03;
        go();
        run(13); chk("t1_not_yet_halted", halted, 0);
        run(1);  chk("t1_halted", halted, 1);
        chk("t1_acc", acc, 8'h08);
        chk("t1_ram_f2", ram[8'hF2], 8'h08);
        chk("t1_pc", pc, 8'h04);

        // FF + 01 overflows to 00 with zero and carry, then JC 3 is taken
        start(0);
        image[8'h00] = 8'h84; image[8'h03] = 8'hF0; image[8'h04] = 8'hD0; image[8'h05] = 8'h04;
        image[8'h06] = 8'h55; image[8'h07] = 8'hA3; image[8'h08] = 8'hD7; image[8'h09] = 8'hF0;
        image[8'hF4] = 8'h00; image[8'hF5] = 8'h01;
        go();
        run(14); chk("t2_acc", acc, 8'h00); chk("t2_zero", zero, 1); chk("t2_carry", carry, 1);
        run(3);  chk("t2_jc_pc", pc, 8'h03);
        run(3);  chk("t2_halted", halted, 1); chk("t2_pc", pc, 8'h04);

        // 02 - 05 borrows, JZ not taken
        start(0);
        image[8'h00] = 8'hD2; image[8'h01] = 8'h66; image[8'h02] = 8'h9F; image[8'h03] = 8'hF0;
        image[8'hF6] = 8'h05;
        go();
        run(7); chk("t3_acc", acc, 8'hFD); chk("t3_carry", carry, 1); chk("t3_zero", zero, 0);
        run(3); chk("t3_jz_pc", pc, 8'h03);
        run(3); chk("t3_halted", halted, 1);

        // every access stalls 3 cycles
        start(3);
        image[8'h00] = 8'hD1; image[8'h01] = 8'h77; image[8'h02] = 8'h18; image[8'h03] = 8'h29;
        image[8'h04] = 8'hF0; image[8'hF7] = 8'h80; image[8'hF8] = 8'h0F; image[8'hF9] = 8'h3C;
        go();
        #1 chk("t4_first_req", mem_req, 1); chk("t4_first_addr", mem_addr, 8'h00);
        run(16); chk("t4_or", acc, 8'h81);
        run(10); chk("t4_xor", acc, 8'h8E);
        run(10); chk("t4_and", acc, 8'h0C);
        run(5);  chk("t4_not_yet_halted", halted, 0);
        run(1);  chk("t4_halted", halted, 1);

        // reset while a STORE request is pending
        start(0);
        image[8'h00] = 8'hD9; image[8'h01] = 8'h3A; image[8'h02] = 8'hF0; image[8'hFA] = 8'h55;
        go();
        run(4); stall = 100;
        run(2);
        chk("t5_store_req", mem_req, 1); chk("t5_store_we", mem_we, 1);
        chk("t5_store_addr", mem_addr, 8'hFA); chk("t5_store_wdata", mem_wdata, 8'h09);
        #2 reset = 1'b1;
        #1 chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0); chk("rst_pc", pc, 0); chk("rst_ir", ir, 0);
        chk("rst_acc", acc, 0); chk("rst_zero", zero, 0); chk("rst_carry", carry, 0);
        chk("rst_halted", halted, 0);
        run(2); chk("t5_ram_kept", ram[8'hFA], 8'h55);
        stall = 0;
        @(posedge clock); #2 reset = 1'b0;
        #1 chk("t5_req_after_rst", mem_req, 1); chk("t5_addr_after_rst", mem_addr, 8'h00);
        run(10); chk("t5_halted", halted, 1); chk("t5_ram_stored", ram[8'hFA], 8'h09);

        // SHL without the shift option, then pc wraps FF -> 00
        start(0);
        image[8'h00] = 8'h0E; image[8'h01] = 8'hB0; image[8'hFE] = 8'h7E;
        go();
        run(7);
        chk("t6_shl_acc", acc, SHIFT_EN ? 8'h02 : 8'h81);
        chk("t6_shl_carry", carry, SHIFT_EN ? 1 : 0);
        chk("t6_shl_zero", zero, 0);
        run(760); chk("t6_pc_ff", pc, 8'hFF); chk("t6_acc", acc, SHIFT_EN ? 8'h7E : 8'hFF);
        run(1);   chk("t6_pc_wrap", pc, 8'h00);

        reset = 1'b1;
        run(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
